pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage core. It produces the ra/rb forwarding selects consumed by the ID stage, and the per-stage stall and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use interlocks, taken-jump redirects, memory/fetch busy and the multi-cycle EX handshake, and it keeps two saturating performance counters. It sits beside the datapath and is driven by the decoder outputs and the ID/EX and EX/MEM pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_if.sv | 59 +++++
 rtl/pipe_ctrl_fwd_sel.sv | 39 +++
 rtl/pipe_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: forwarding selects,
// FSM state encodings, memory-op codes and a load-decode helper.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int MEM_OP_BUS = 2;

  typedef logic [1:0] fwd_ctrl_t;

  // Forwarding select encodings seen by the ID-stage operand muxes
  localparam fwd_ctrl_t FWD_CTRL_NONE = 2'b00;
  localparam fwd_ctrl_t FWD_CTRL_EX   = 2'b01;
  localparam fwd_ctrl_t FWD_CTRL_MEM  = 2'b10;

  // Controller FSM state encodings
  localparam logic [1:0] PIPE_ST_RUN     = 2'd0;
  localparam logic [1:0] PIPE_ST_MC_BUSY = 2'd1;
  localparam logic [1:0] PIPE_ST_MC_DONE = 2'd2;

  // Memory operation codes carried in the ID/EX register
  localparam logic [MEM_OP_BUS-1:0] MEM_OP_NOP = 2'd0;
  localparam logic [MEM_OP_BUS-1:0] MEM_OP_LDW = 2'd1;
  localparam logic [MEM_OP_BUS-1:0] MEM_OP_STW = 2'd2;
  localparam logic [MEM_OP_BUS-1:0] MEM_OP_LDB = 2'd3;

  // True when the memory op returns its result only in MEM (a load)
  function automatic logic is_load(input logic [MEM_OP_BUS-1:0] op);
    return (op == MEM_OP_LDW) || (op == MEM_OP_LDB);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath-facing bundle of the pipeline controller: decoder fields,
// pipeline-register fields, busy/handshake inputs and the control strobes.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] ra_addr;
  logic [REG_ADDR_W-1:0] rb_addr;
  logic [1:0]            src_reg_used;

  logic                  id_en;
  logic [REG_ADDR_W-1:0] id_dst_addr;
  logic                  id_gpr_we_;
  logic [MEM_OP_BUS-1:0] id_mem_op;
  logic                  id_jump_taken;
  logic                  id_mc_op;

  logic                  ex_en;
  logic [REG_ADDR_W-1:0] ex_dst_addr;
  logic                  ex_gpr_we_;

  logic                  if_busy;
  logic                  mem_busy;
  logic                  mc_done;

  fwd_ctrl_t             ra_fwd_ctrl;
  fwd_ctrl_t             rb_fwd_ctrl;
  logic                  if_stall;
  logic                  id_stall;
  logic                  ex_stall;
  logic                  mem_stall;
  logic                  if_flush;
  logic                  id_flush;
  logic                  ex_flush;
  logic                  mem_flush;
  logic                  mc_start;

  modport master (
    output ra_addr, rb_addr, src_reg_used,
    output id_en, id_dst_addr, id_gpr_we_, id_mem_op, id_jump_taken, id_mc_op,
    output ex_en, ex_dst_addr, ex_gpr_we_,
    output if_busy, mem_busy, mc_done,
    input  ra_fwd_ctrl, rb_fwd_ctrl,
    input  if_stall, id_stall, ex_stall, mem_stall,
    input  if_flush, id_flush, ex_flush, mem_flush,
    input  mc_start
  );

  modport slave (
    input  ra_addr, rb_addr, src_reg_used,
    input  id_en, id_dst_addr, id_gpr_we_, id_mem_op, id_jump_taken, id_mc_op,
    input  ex_en, ex_dst_addr, ex_gpr_we_,
    input  if_busy, mem_busy, mc_done,
    output ra_fwd_ctrl, rb_fwd_ctrl,
    output if_stall, id_stall, ex_stall, mem_stall,
    output if_flush, id_flush, ex_flush, mem_flush,
    output mc_start
  );

endinterface

// File: rtl/pipe_ctrl_fwd_sel.sv
// Per-operand forwarding select. An EX-stage producer beats a MEM-stage one;
// a load in EX cannot forward yet, so it reports a load hazard instead.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  used,
  input  logic                  id_en,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_gpr_we_,
  input  logic                  id_is_load,
  input  logic                  ex_en,
  input  logic [REG_ADDR_W-1:0] ex_dst_addr,
  input  logic                  ex_gpr_we_,
  output fwd_ctrl_t             sel,
  output logic                  load_hazard
);

  logic src_valid;
  logic ex_match;
  logic mem_match;

  // Compare the operand against both producers and pick the youngest one
  always_comb begin
    src_valid   = used && (addr != '0);
    ex_match    = src_valid && id_en && !id_gpr_we_ && (id_dst_addr == addr);
    mem_match   = src_valid && ex_en && !ex_gpr_we_ && (ex_dst_addr == addr);
    load_hazard = ex_match && id_is_load;
    sel         = FWD_CTRL_NONE;
    if (ex_match) begin
      if (!id_is_load) begin
        sel = FWD_CTRL_EX;
      end
    end else if (mem_match) begin
      sel = FWD_CTRL_MEM;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: forwarding selects, per-stage stall/flush strobes,
// multi-cycle EX handshake FSM and saturating stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_ctrl_if.slave       bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fwd_ctrl_t ra_sel;
  fwd_ctrl_t rb_sel;
  logic      ra_hazard;
  logic      rb_hazard;
  logic      id_is_load;

  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic redirect;
  logic mc_go;
  logic redirect_applied;
  logic if_stall, id_stall, ex_stall, mem_stall;
  logic if_flush, id_flush, ex_flush, mem_flush;
  logic mc_start;

  assign id_is_load = is_load(bus.id_mem_op);

  fwd_sel u_fwd_ra (
    .addr        (bus.ra_addr),
    .used        (bus.src_reg_used[0]),
    .id_en       (bus.id_en),
    .id_dst_addr (bus.id_dst_addr),
    .id_gpr_we_  (bus.id_gpr_we_),
    .id_is_load  (id_is_load),
    .ex_en       (bus.ex_en),
    .ex_dst_addr (bus.ex_dst_addr),
    .ex_gpr_we_  (bus.ex_gpr_we_),
    .sel         (ra_sel),
    .load_hazard (ra_hazard)
  );

  fwd_sel u_fwd_rb (
    .addr        (bus.rb_addr),
    .used        (bus.src_reg_used[1]),
    .id_en       (bus.id_en),
    .id_dst_addr (bus.id_dst_addr),
    .id_gpr_we_  (bus.id_gpr_we_),
    .id_is_load  (id_is_load),
    .ex_en       (bus.ex_en),
    .ex_dst_addr (bus.ex_dst_addr),
    .ex_gpr_we_  (bus.ex_gpr_we_),
    .sel         (rb_sel),
    .load_hazard (rb_hazard)
  );

  assign load_use = ra_hazard || rb_hazard;
  assign redirect = bus.id_en && bus.id_jump_taken;
  assign mc_go    = bus.id_en && bus.id_mc_op;

  // Stall/flush arbitration: reset bubbles everything, mem_busy freezes all
  // stages, then the FSM state decides between the RUN hazards and the MC hold
  always_comb begin
    state_d          = state_q;
    if_stall         = 1'b0;
    id_stall         = 1'b0;
    ex_stall         = 1'b0;
    mem_stall        = 1'b0;
    if_flush         = 1'b0;
    id_flush         = 1'b0;
    ex_flush         = 1'b0;
    mem_flush        = 1'b0;
    mc_start         = 1'b0;
    redirect_applied = 1'b0;
    if (reset) begin
      state_d   = PIPE_ST_RUN;
      if_flush  = 1'b1;
      id_flush  = 1'b1;
      ex_flush  = 1'b1;
      mem_flush = 1'b1;
    end else if (bus.mem_busy) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
      if ((state_q == PIPE_ST_MC_BUSY) && bus.mc_done) begin
        state_d = PIPE_ST_MC_DONE;
      end
    end else begin
      case (state_q)
        PIPE_ST_RUN: begin
          if (mc_go) begin
            mc_start = 1'b1;
            if_stall = 1'b1;
            id_stall = 1'b1;
            ex_flush = 1'b1;
            state_d  = PIPE_ST_MC_BUSY;
          end else begin
            if (redirect) begin
              if_flush         = 1'b1;
              id_flush         = 1'b1;
              redirect_applied = 1'b1;
            end else if (load_use) begin
              if_stall = 1'b1;
              id_flush = 1'b1;
            end
            // A fetch miss bubbles IF/ID unless load-use must keep the ID instruction
            if (bus.if_busy) begin
              if_stall = 1'b1;
              if (redirect || !load_use) begin
                if_flush = 1'b1;
              end
            end
          end
        end
        PIPE_ST_MC_BUSY: begin
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_flush = 1'b1;
          if (bus.mc_done) begin
            state_d = PIPE_ST_MC_DONE;
          end
        end
        PIPE_ST_MC_DONE: begin
          state_d = PIPE_ST_RUN;
          if (bus.if_busy) begin
            if_stall = 1'b1;
            if_flush = 1'b1;
          end
        end
        default: begin
          state_d = PIPE_ST_RUN;
        end
      endcase
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (if_stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (redirect_applied && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PIPE_ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ra_fwd_ctrl = reset ? FWD_CTRL_NONE : ra_sel;
  assign bus.rb_fwd_ctrl = reset ? FWD_CTRL_NONE : rb_sel;
  assign bus.if_stall    = if_stall;
  assign bus.id_stall    = id_stall;
  assign bus.ex_stall    = ex_stall;
  assign bus.mem_stall   = mem_stall;
  assign bus.if_flush    = if_flush;
  assign bus.id_flush    = id_flush;
  assign bus.ex_flush    = ex_flush;
  assign bus.mem_flush   = mem_flush;
  assign bus.mc_start    = mc_start;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: forwarding, load-use, redirect, busy
// handling, multi-cycle handshake, reset and counter saturation.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        cnt_clr;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  int          checks;
  int          errors;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  logic [3:0] stalls;
  logic [3:0] flushes;
  assign stalls  = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall};
  assign flushes = {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.ra_addr       = 5'd0;
    bus.rb_addr       = 5'd0;
    bus.src_reg_used  = 2'b00;
    bus.id_en         = 1'b0;
    bus.id_dst_addr   = 5'd0;
    bus.id_gpr_we_    = 1'b1;
    bus.id_mem_op     = MEM_OP_NOP;
    bus.id_jump_taken = 1'b0;
    bus.id_mc_op      = 1'b0;
    bus.ex_en         = 1'b0;
    bus.ex_dst_addr   = 5'd0;
    bus.ex_gpr_we_    = 1'b1;
    bus.if_busy       = 1'b0;
    bus.mem_busy      = 1'b0;
    bus.mc_done       = 1'b0;
    cnt_clr           = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    bus.id_en = 1'b1; bus.id_jump_taken = 1'b1; bus.id_dst_addr = 5'd3;
    bus.id_gpr_we_ = 1'b0; bus.ra_addr = 5'd3; bus.src_reg_used = 2'b01;
    #1;
    checks++; if (flushes !== 4'b1111) begin errors++; $display("[TB] FAIL reset_flushes: got %b expected 1111", flushes); end
    checks++; if (stalls !== 4'b0000) begin errors++; $display("[TB] FAIL reset_stalls: got %b expected 0000", stalls); end
    checks++; if (bus.ra_fwd_ctrl !== FWD_CTRL_NONE) begin errors++; $display("[TB] FAIL reset_ra_fwd: got %b expected 00", bus.ra_fwd_ctrl); end
    checks++; if (bus.mc_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_mc_start: got %b expected 0", bus.mc_start); end
    step();
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0h/%0h expected 0/0", stall_cnt, flush_cnt); end
    reset = 1'b0;
    set_idle();
  endtask

  task automatic test_forward();
    set_idle();
    bus.id_en = 1'b1; bus.id_dst_addr = 5'd3; bus.id_gpr_we_ = 1'b0;
    bus.ra_addr = 5'd3; bus.rb_addr = 5'd3; bus.src_reg_used = 2'b11;
    #1;
    checks++; if (bus.ra_fwd_ctrl !== FWD_CTRL_EX || bus.rb_fwd_ctrl !== FWD_CTRL_EX) begin errors++; $display("[TB] FAIL fwd_ex: got %b/%b expected 01/01", bus.ra_fwd_ctrl, bus.rb_fwd_ctrl); end
    checks++; if (stalls !== 4'b0000 || flushes !== 4'b0000) begin errors++; $display("[TB] FAIL fwd_ex_strobes: got %b/%b expected 0000/0000", stalls, flushes); end
    bus.ex_en = 1'b1; bus.ex_dst_addr = 5'd3; bus.ex_gpr_we_ = 1'b0;
    #1;
    checks++; if (bus.ra_fwd_ctrl !== FWD_CTRL_EX || bus.rb_fwd_ctrl !== FWD_CTRL_EX) begin errors++; $display("[TB] FAIL fwd_ex_beats_mem: got %b/%b expected 01/01", bus.ra_fwd_ctrl, bus.rb_fwd_ctrl); end
    bus.id_en = 1'b0;
    #1;
    checks++; if (bus.ra_fwd_ctrl !== FWD_CTRL_MEM || bus.rb_fwd_ctrl !== FWD_CTRL_MEM) begin errors++; $display("[TB] FAIL fwd_mem: got %b/%b expected 10/10", bus.ra_fwd_ctrl, bus.rb_fwd_ctrl); end
    bus.src_reg_used = 2'b01;
    #1;
    checks++; if (bus.ra_fwd_ctrl !== FWD_CTRL_MEM || bus.rb_fwd_ctrl !== FWD_CTRL_NONE) begin errors++; $display("[TB] FAIL fwd_unused: got %b/%b expected 10/00", bus.ra_fwd_ctrl, bus.rb_fwd_ctrl); end
    bus.ra_addr = 5'd0; bus.ex_dst_addr = 5'd0;
    #1;
    checks++; if (bus.ra_fwd_ctrl !== FWD_CTRL_NONE) begin errors++; $display("[TB] FAIL fwd_r0: got %b expected 00", bus.ra_fwd_ctrl); end
    step();
  endtask

  task automatic test_load_use();
    set_idle();
    bus.id_en = 1'b1; bus.id_dst_addr = 5'd5; bus.id_gpr_we_ = 1'b0; bus.id_mem_op = MEM_OP_LDW;
    bus.ra_addr = 5'd7; bus.rb_addr = 5'd5; bus.src_reg_used = 2'b11;
    #1;
    checks++; if (stalls !== 4'b1000 || flushes !== 4'b0100) begin errors++; $display("[TB] FAIL load_use_strobes: got %b/%b expected 1000/0100", stalls, flushes); end
    checks++; if (bus.rb_fwd_ctrl !== FWD_CTRL_NONE || bus.ra_fwd_ctrl !== FWD_CTRL_NONE) begin errors++; $display("[TB] FAIL load_use_fwd: got %b/%b expected 00/00", bus.ra_fwd_ctrl, bus.rb_fwd_ctrl); end
    step();
    set_idle();
    bus.ex_en = 1'b1; bus.ex_dst_addr = 5'd5; bus.ex_gpr_we_ = 1'b0;
    bus.ra_addr = 5'd7; bus.rb_addr = 5'd5; bus.src_reg_used = 2'b11;
    #1;
    checks++; if (bus.rb_fwd_ctrl !== FWD_CTRL_MEM) begin errors++; $display("[TB] FAIL load_use_resolve: got %b expected 10", bus.rb_fwd_ctrl); end
    checks++; if (stalls !== 4'b0000) begin errors++; $display("[TB] FAIL load_use_no_stall: got %b expected 0000", stalls); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
    step();
  endtask

  task automatic test_redirect();
    set_idle();
    bus.id_en = 1'b1; bus.id_jump_taken = 1'b1;
    bus.id_dst_addr = 5'd5; bus.id_gpr_we_ = 1'b0; bus.id_mem_op = MEM_OP_LDW;
    bus.rb_addr = 5'd5; bus.src_reg_used = 2'b10;
    #1;
    checks++; if (flushes !== 4'b1100) begin errors++; $display("[TB] FAIL redirect_flushes: got %b expected 1100", flushes); end
    checks++; if (stalls !== 4'b0000) begin errors++; $display("[TB] FAIL redirect_suppress_load_use: got %b expected 0000", stalls); end
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("[TB] FAIL redirect_cnt_before: got %0d expected 0", flush_cnt); end
    step();
    set_idle();
    #1;
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("[TB] FAIL redirect_cnt_after: got %0d expected 1", flush_cnt); end
    checks++; if (flushes !== 4'b0000) begin errors++; $display("[TB] FAIL redirect_one_cycle: got %b expected 0000", flushes); end
  endtask

  task automatic test_redirect_mem_busy();
    set_idle();
    bus.id_en = 1'b1; bus.id_jump_taken = 1'b1; bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stalls !== 4'b1111 || flushes !== 4'b0000) begin errors++; $display("[TB] FAIL mem_busy_hold_%0d: got %b/%b expected 1111/0000", i, stalls, flushes); end
      step();
    end
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("[TB] FAIL mem_busy_no_count: got %0d expected 1", flush_cnt); end
    bus.mem_busy = 1'b0;
    #1;
    checks++; if (flushes !== 4'b1100 || stalls !== 4'b0000) begin errors++; $display("[TB] FAIL mem_busy_release: got %b/%b expected 1100/0000", flushes, stalls); end
    step();
    set_idle();
    #1;
    checks++; if (flush_cnt !== 16'd2) begin errors++; $display("[TB] FAIL mem_busy_cnt_after: got %0d expected 2", flush_cnt); end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("[TB] FAIL mem_busy_stall_cnt: got %0d expected 4", stall_cnt); end
  endtask

  task automatic test_if_busy();
    set_idle();
    bus.if_busy = 1'b1;
    #1;
    checks++; if (stalls !== 4'b1000 || flushes !== 4'b1000) begin errors++; $display("[TB] FAIL if_busy: got %b/%b expected 1000/1000", stalls, flushes); end
    bus.id_en = 1'b1; bus.id_jump_taken = 1'b1;
    #1;
    checks++; if (stalls !== 4'b1000 || flushes !== 4'b1100) begin errors++; $display("[TB] FAIL if_busy_redirect: got %b/%b expected 1000/1100", stalls, flushes); end
    step();
    set_idle();
  endtask

  task automatic test_multicycle();
    set_idle();
    bus.id_en = 1'b1; bus.id_mc_op = 1'b1; bus.id_dst_addr = 5'd9; bus.id_gpr_we_ = 1'b0;
    #1;
    checks++; if (bus.mc_start !== 1'b1 || stalls !== 4'b1100 || flushes !== 4'b0010) begin errors++; $display("[TB] FAIL mc_start_cycle: got %b %b/%b expected 1 1100/0010", bus.mc_start, stalls, flushes); end
    step();
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++; if (bus.mc_start !== 1'b0 || stalls !== 4'b1100 || flushes !== 4'b0010) begin errors++; $display("[TB] FAIL mc_busy_%0d: got %b %b/%b expected 0 1100/0010", i, bus.mc_start, stalls, flushes); end
      step();
    end
    bus.mc_done = 1'b1;
    #1;
    checks++; if (stalls !== 4'b1100) begin errors++; $display("[TB] FAIL mc_done_cycle: got %b expected 1100", stalls); end
    step();
    bus.mc_done = 1'b0;
    #1;
    checks++; if (stalls !== 4'b0000 || flushes !== 4'b0000 || bus.mc_start !== 1'b0) begin errors++; $display("[TB] FAIL mc_release: got %b/%b %b expected 0000/0000 0", stalls, flushes, bus.mc_start); end
    step();
    set_idle();
    bus.mc_done = 1'b1;
    #1;
    checks++; if (stalls !== 4'b0000) begin errors++; $display("[TB] FAIL mc_done_in_run: got %b expected 0000", stalls); end
    step();
    set_idle();
    bus.id_en = 1'b1; bus.id_mc_op = 1'b1;
    #1;
    checks++; if (bus.mc_start !== 1'b1) begin errors++; $display("[TB] FAIL mc_back_to_run: got %b expected 1", bus.mc_start); end
    step();
  endtask

  task automatic test_reset_mid_mc();
    #1;
    checks++; if (stalls !== 4'b1100) begin errors++; $display("[TB] FAIL mid_mc_busy: got %b expected 1100", stalls); end
    reset = 1'b1;
    #1;
    checks++; if (flushes !== 4'b1111 || stalls !== 4'b0000 || bus.mc_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_mc_reset: got %b/%b %b expected 1111/0000 0", flushes, stalls, bus.mc_start); end
    step();
    reset = 1'b0;
    set_idle();
    #1;
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_mc_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
    checks++; if (stalls !== 4'b0000) begin errors++; $display("[TB] FAIL mid_mc_state_run: got %b expected 0000", stalls); end
    bus.id_en = 1'b1; bus.id_jump_taken = 1'b1;
    #1;
    checks++; if (flushes !== 4'b1100) begin errors++; $display("[TB] FAIL mid_mc_redirect_run: got %b expected 1100", flushes); end
    step();
    set_idle();
  endtask

  task automatic test_saturation();
    set_idle();
    bus.if_busy = 1'b1;
    for (int i = 0; i < 65541; i++) begin
      step();
    end
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL stall_cnt_saturate: got %0h expected ffff", stall_cnt); end
    cnt_clr = 1'b1;
    #1;
    step();
    set_idle();
    #1;
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("[TB] FAIL cnt_clr_priority: got %0h/%0h expected 0/0", stall_cnt, flush_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_idle();
    step();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_redirect_mem_busy();
    test_if_busy();
    test_multicycle();
    test_reset_mid_mc();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
